signed_sat_accumulator: RTL and testbench

//   Downstream consumer of the 4-bit signed saturating adder stage.

---
 rtl/signed_sat_accumulator.sv | 114 +++++++++++
 tb/tb_signed_sat_accumulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/signed_sat_accumulator.sv
// Frame accumulator with per-step signed saturation; result valid the cycle after the last beat, upstream stalled in HOLD.
// The sticky down_sat port exists only when SIGNED_SAT_ACC_FLAG_EN is defined.
module signed_sat_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_W     = 6,
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [ACC_W-1:0] down_data
`ifdef SIGNED_SAT_ACC_FLAG_EN
  ,
  output logic             down_sat
`endif
);

  localparam int               CNT_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_step;
  logic             clamp;
`ifdef SIGNED_SAT_ACC_FLAG_EN
  logic             sat_q, sat_d;
`endif

  // One guard bit is enough: |acc + sample| never exceeds twice the accumulator range.
  assign sum   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-WIDTH){up_data[WIDTH-1]}}, up_data};
  assign clamp = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    acc_step = sum[ACC_W-1:0];
    if (clamp) acc_step = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    up_ready   = 1'b0;
    down_valid = 1'b0;
`ifdef SIGNED_SAT_ACC_FLAG_EN
    sat_d      = sat_q;
`endif
    case (state_q)
      ACCUM: begin
        up_ready = 1'b1;
        if (up_valid) begin
          acc_d = acc_step;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SIGNED_SAT_ACC_FLAG_EN
          sat_d = sat_q | clamp;
`endif
          if (cnt_q == LAST) begin
            data_d  = acc_step;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        down_valid = 1'b1;
        if (down_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SIGNED_SAT_ACC_FLAG_EN
          sat_d   = 1'b0;
`endif
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef SIGNED_SAT_ACC_FLAG_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef SIGNED_SAT_ACC_FLAG_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign down_data = data_q;
`ifdef SIGNED_SAT_ACC_FLAG_EN
  assign down_sat  = sat_q;
`endif

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Bench for signed_sat_accumulator: frame vectors, reset corner cases and random frames against a clamp-per-step model.
module tb_signed_sat_accumulator;
  localparam int WIDTH     = 4;
  localparam int ACC_W     = 6;
  localparam int FRAME_LEN = 8;
  localparam int MAXV      = (1 << (ACC_W - 1)) - 1;
  localparam int MINV      = -(1 << (ACC_W - 1));

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             up_valid = 1'b0;
  logic             up_ready;
  logic [WIDTH-1:0] up_data = '0;
  logic             down_valid;
  logic             down_ready = 1'b0;
  logic [ACC_W-1:0] down_data;
  logic             down_sat;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  signed_sat_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_data (down_data)
`ifdef SIGNED_SAT_ACC_FLAG_EN
    ,
    .down_sat  (down_sat)
`endif
  );

`ifndef SIGNED_SAT_ACC_FLAG_EN
  assign down_sat = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]       s;
    logic [7:0]        bub;
    logic [7:0]        hold;
    logic signed [7:0] exp_d;
    logic              exp_sat;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dd();
    return int'($signed(down_data));
  endfunction

  task automatic chk_sat(input string name, input bit exp);
`ifdef SIGNED_SAT_ACC_FLAG_EN
    chk(name, int'(down_sat), int'(exp));
`endif
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    up_valid = 1'b1;
    up_data  = d;
    while (!done && n < 50) begin
      done = up_ready;
      step();
      n++;
    end
    up_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic run_frame(input string name, input logic [31:0] s, input int bub, input int hold,
                           input int exp_d, input bit exp_sat);
    int nb;
    for (int i = 0; i < FRAME_LEN; i++) begin
      nb = 0;
      while (bub > 0 && int'($urandom_range(99)) < bub && nb < 4) begin
        up_valid = 1'b0;
        up_data  = 4'($urandom);
        step();
        nb++;
      end
      push(s[4*i +: 4]);
    end
    chk({name, "_vld"}, int'(down_valid), 1);
    chk({name, "_data"}, dd(), exp_d);
    chk({name, "_rdy_hold"}, int'(up_ready), 0);
    chk_sat({name, "_sat"}, exp_sat);
    for (int h = 0; h < hold; h++) begin
      up_valid = 1'b1;
      up_data  = 4'($urandom);
      step();
      chk({name, "_hold_vld"}, int'(down_valid), 1);
      chk({name, "_hold_data"}, dd(), exp_d);
      chk({name, "_hold_rdy"}, int'(up_ready), 0);
    end
    up_valid   = 1'b0;
    down_ready = 1'b1;
    step();
    down_ready = 1'b0;
    chk({name, "_vld_drop"}, int'(down_valid), 0);
    chk({name, "_rdy_back"}, int'(up_ready), 1);
  endtask

  function automatic void model(input logic [31:0] s, output int tot, output bit sat);
    logic signed [WIDTH-1:0] x;
    tot = 0;
    sat = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      x = s[4*i +: 4];
      tot = tot + int'(x);
      if (tot > MAXV) begin tot = MAXV; sat = 1'b1; end
      if (tot < MINV) begin tot = MINV; sat = 1'b1; end
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  etot;
    bit  esat;
    logic [31:0] rs;

    // Sample nibble i is beat i; hex strings read last beat first.
    tbl[0] = '{s: 32'h33333333, bub: 8'd0,  hold: 8'd0, exp_d: 8'sd24,  exp_sat: 1'b0};
    tbl[1] = '{s: 32'h77777777, bub: 8'd0,  hold: 8'd0, exp_d: 8'sd31,  exp_sat: 1'b1};
    tbl[2] = '{s: 32'h88888888, bub: 8'd0,  hold: 8'd0, exp_d: -8'sd32, exp_sat: 1'b1};
    tbl[3] = '{s: 32'h87777777, bub: 8'd0,  hold: 8'd0, exp_d: 8'sd23,  exp_sat: 1'b1};
    tbl[4] = '{s: 32'h77777778, bub: 8'd0,  hold: 8'd0, exp_d: 8'sd31,  exp_sat: 1'b1};
    tbl[5] = '{s: 32'h11111111, bub: 8'd0,  hold: 8'd5, exp_d: 8'sd8,   exp_sat: 1'b0};
    tbl[6] = '{s: 32'h11111111, bub: 8'd0,  hold: 8'd0, exp_d: 8'sd8,   exp_sat: 1'b0};
    tbl[7] = '{s: 32'h00037777, bub: 8'd30, hold: 8'd1, exp_d: 8'sd31,  exp_sat: 1'b0};
    tbl[8] = '{s: 32'h00008888, bub: 8'd30, hold: 8'd2, exp_d: -8'sd32, exp_sat: 1'b0};
    tbl[9] = '{s: 32'hF1F1F1F1, bub: 8'd50, hold: 8'd0, exp_d: 8'sd0,   exp_sat: 1'b0};

    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_rdy", int'(up_ready), 1);
    chk("rst_vld", int'(down_valid), 0);
    chk("rst_data", dd(), 0);
    chk_sat("rst_sat", 1'b0);

    // Async reset while a saturated result is pending in HOLD.
    for (int i = 0; i < FRAME_LEN; i++) push(4'd7);
    chk("pre_rst_vld", int'(down_valid), 1);
    chk("pre_rst_data", dd(), 31);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_vld", int'(down_valid), 0);
    chk("async_rst_data", dd(), 0);
    chk("async_rst_rdy", int'(up_ready), 1);
    chk_sat("async_rst_sat", 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_rdy", int'(up_ready), 1);
    chk("post_rst_vld", int'(down_valid), 0);
    chk("post_rst_data", dd(), 0);

    for (int i = 0; i < 10; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].s, int'(tbl[i].bub), int'(tbl[i].hold),
                int'(tbl[i].exp_d), tbl[i].exp_sat);

    // Partial frame discarded by reset.
    for (int i = 0; i < 3; i++) push(4'd5);
    #2;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    run_frame("midrst", 32'h11111111, 0, 0, 8, 1'b0);
    for (int i = 0; i < 3; i++) push(4'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_frame("midrst_bub", 32'h11111111, 40, 1, 8, 1'b0);

    for (int k = 0; k < 25; k++) begin
      rs = $urandom;
      model(rs, etot, esat);
      run_frame($sformatf("rnd%0d", k), rs, int'($urandom_range(50)), int'($urandom_range(3)), etot, esat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
